updown_sweep_ctrl: RTL and testbench

//  Sequencer for the loadable up/down counter. On a start request it latches a
//  [lo,hi] window and a sweep count, then drives the counter as a triangle wave:
//  lo..hi..lo. It repeats this N times, pulses done and returns to idle.

---
 rtl/updown_sweep_pkg.sv | 14 +
 rtl/updown_counter_ld.sv | 33 +++
 rtl/updown_sweep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/updown_sweep_pkg.sv
// rtl/updown_sweep_pkg.sv - shared state encoding and counter mode constants
package updown_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/updown_counter_ld.sv
// rtl/updown_counter_ld.sv - loadable up/down counter, load wins over enable
module updown_counter_ld
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Count register: load takes priority, otherwise step by one in the selected direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= (mode == MODE_DOWN) ? (r_count - ONE) : (r_count + ONE);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangle-wave sweep sequencer driving the loadable counter
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SWEEP_W-1:0] ONE_S = {{(SWEEP_W-1){1'b0}}, 1'b1};

  sweep_state_t       r_state;
  logic               r_mode;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [SWEEP_W-1:0] r_sweep_cnt;
  logic [WIDTH-1:0]   r_lo_q;
  logic [WIDTH-1:0]   r_hi_q;
  logic [SWEEP_W-1:0] r_n_q;

  sweep_state_t       w_state_nxt;
  logic               w_mode_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic [SWEEP_W-1:0] w_sweep_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [SWEEP_W-1:0] w_n_nxt;
  logic               w_cnt_en;
  logic               w_cnt_load;
  logic [WIDTH-1:0]   w_cnt_load_val;
  logic [WIDTH-1:0]   w_cnt;
  logic [SWEEP_W-1:0] w_sweep_inc;
  logic               w_start_ok;

  assign w_sweep_inc = r_sweep_cnt + ONE_S;
  assign w_start_ok  = (lo < hi) && (n_sweeps != '0);

  updown_counter_ld #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (w_cnt_en),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .mode     (r_mode),
    .count    (w_cnt)
  );

  // Next-state, counter control and next output values; turnarounds use loads so the count never wraps.
  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_sweep_nxt    = r_sweep_cnt;
    w_lo_nxt       = r_lo_q;
    w_hi_nxt       = r_hi_q;
    w_n_nxt        = r_n_q;
    w_cnt_en       = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = r_lo_q;

    if ((r_state != ST_IDLE) && abort) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_busy_nxt = 1'b0;
          if (start) begin
            if (w_start_ok) begin
              w_lo_nxt       = lo;
              w_hi_nxt       = hi;
              w_n_nxt        = n_sweeps;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = lo;
              w_state_nxt    = ST_UP;
              w_mode_nxt     = MODE_UP;
              w_busy_nxt     = 1'b1;
              w_sweep_nxt    = '0;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        ST_UP: begin
          if (w_cnt >= r_hi_q) begin
            w_state_nxt    = ST_DOWN;
            w_mode_nxt     = MODE_DOWN;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = r_hi_q - ONE_W;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        ST_DOWN: begin
          if (w_cnt <= r_lo_q) begin
            w_sweep_nxt = w_sweep_inc;
            if (w_sweep_inc == r_n_q) begin
              w_state_nxt = ST_DONE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt    = ST_UP;
              w_mode_nxt     = MODE_UP;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = r_lo_q + ONE_W;
            end
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State, latched window and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_UP;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
      r_lo_q      <= '0;
      r_hi_q      <= '0;
      r_n_q       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      r_lo_q      <= w_lo_nxt;
      r_hi_q      <= w_hi_nxt;
      r_n_q       <= w_n_nxt;
    end
  end

  assign count     = w_cnt;
  assign mode      = r_mode;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - directed self-checking bench for the sweep sequencer
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [7:0] n_sweeps;
  logic [3:0] count;
  logic       mode;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sweep_cnt;

  int n_cmp;
  int n_mis;

  updown_sweep_ctrl #(
    .WIDTH   (4),
    .SWEEP_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .lo        (lo),
    .hi        (hi),
    .n_sweeps  (n_sweeps),
    .count     (count),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int l, input int h, input int n);
    lo       = 4'(l);
    hi       = 4'(h);
    n_sweeps = 8'(n);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // lo=2 hi=4 n=2 expected trace
  int t1_cnt [9] = '{2, 3, 4, 3, 2, 3, 4, 3, 2};
  int t1_mode[9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
  int t1_swp [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  int t5_cnt [5] = '{2, 3, 4, 3, 2};
  int t6_cnt [5] = '{3, 4, 5, 4, 3};

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    lo       = '0;
    hi       = '0;
    n_sweeps = '0;
    step();
    step();

    chk("rst_count", int'(count), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sweep", int'(sweep_cnt), 0);

    @(negedge clk);
    reset = 1'b1;

    // 1: lo=2 hi=4 n=2
    kick(2, 4, 2);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) step();
      chk($sformatf("t1_count[%0d]", i), int'(count), t1_cnt[i]);
      chk($sformatf("t1_mode[%0d]", i), int'(mode), t1_mode[i]);
      chk($sformatf("t1_busy[%0d]", i), int'(busy), 1);
      chk($sformatf("t1_sweep[%0d]", i), int'(sweep_cnt), t1_swp[i]);
      chk($sformatf("t1_done[%0d]", i), int'(done), 0);
    end
    step();
    chk("t1_done_pulse", int'(done), 1);
    chk("t1_done_busy", int'(busy), 0);
    chk("t1_done_count", int'(count), 2);
    chk("t1_done_sweep", int'(sweep_cnt), 2);
    step();
    chk("t1_done_clear", int'(done), 0);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_count", int'(count), 2);

    // 2: full range, no wrap
    kick(0, 15, 1);
    for (int i = 0; i < 31; i++) begin
      if (i != 0) step();
      chk($sformatf("t2_count[%0d]", i), int'(count), (i <= 15) ? i : 30 - i);
      chk($sformatf("t2_busy[%0d]", i), int'(busy), 1);
    end
    step();
    chk("t2_done_pulse", int'(done), 1);
    chk("t2_done_count", int'(count), 0);
    chk("t2_done_sweep", int'(sweep_cnt), 1);
    step();

    // 3: rejected starts
    kick(5, 5, 1);
    chk("t3a_err", int'(err), 1);
    chk("t3a_busy", int'(busy), 0);
    chk("t3a_count", int'(count), 0);
    step();
    chk("t3a_err_clear", int'(err), 0);
    chk("t3a_busy_idle", int'(busy), 0);
    kick(3, 7, 0);
    chk("t3b_err", int'(err), 1);
    chk("t3b_busy", int'(busy), 0);
    chk("t3b_count", int'(count), 0);
    step();
    chk("t3b_err_clear", int'(err), 0);

    // 4: abort while counting up
    kick(1, 6, 3);
    step();
    step();
    step();
    chk("t4_pre_abort_count", int'(count), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_count", int'(count), 4);
    chk("t4_abort_done", int'(done), 0);
    chk("t4_abort_sweep", int'(sweep_cnt), 0);
    step();
    chk("t4_hold_count", int'(count), 4);
    chk("t4_hold_done", int'(done), 0);
    chk("t4_hold_busy", int'(busy), 0);

    // 5: start mid-run ignored
    kick(2, 4, 1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        if (i == 2) begin
          lo       = 4'd0;
          hi       = 4'd9;
          n_sweeps = 8'd5;
          start    = 1'b1;
        end
        step();
        start = 1'b0;
      end
      chk($sformatf("t5_count[%0d]", i), int'(count), t5_cnt[i]);
      chk($sformatf("t5_err[%0d]", i), int'(err), 0);
    end
    step();
    chk("t5_done_pulse", int'(done), 1);
    chk("t5_done_count", int'(count), 2);
    chk("t5_done_sweep", int'(sweep_cnt), 1);
    step();

    // 6: async reset mid-DOWN, then a clean run
    kick(3, 8, 2);
    for (int i = 0; i < 6; i++) step();
    chk("t6_pre_count", int'(count), 7);
    chk("t6_pre_mode", int'(mode), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_mode", int'(mode), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_sweep", int'(sweep_cnt), 0);
    chk("t6_rst_done", int'(done), 0);
    reset = 1'b1;
    @(negedge clk);
    kick(3, 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      chk($sformatf("t6_count[%0d]", i), int'(count), t6_cnt[i]);
    end
    step();
    chk("t6_done_pulse", int'(done), 1);
    chk("t6_done_sweep", int'(sweep_cnt), 1);
    step();
    chk("t6_done_clear", int'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
